switch_4port: RTL and testbench



---
 rtl/switch_4port.sv | 179 +++++++++++++++++
 tb/tb_switch_4port.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_4port.sv
// ---------------------------------------------------------------------------
// switch_4port
//
// Purpose:
//   Four-port single-beat packet switch. Each ingress buffers packets in a
//   small FIFO whose entries carry {source, target, data, remaining mask}.
//   Each egress runs its own round-robin arbiter over the FIFO heads whose
//   remaining mask names it. One head may be granted by several egresses in
//   the same cycle (multicast). The head pops once every targeted egress has
//   taken its copy.
//
// Configuration macro:
//   SWITCH_SELF_FILTER_EN - when defined, an ingress never delivers to its
//                           own egress. A packet whose only target is its
//                           own port is accepted and discarded. When
//                           undefined, loopback is allowed.
//
// Parameters:
//   DEPTH - entries per ingress FIFO (power of two, >= 2)
//   DW    - payload width
//
// Ports (per-port bundles flattened into packed arrays; index p is port p):
//   clk           in   switch clock, rising edge
//   rst_n         in   synchronous reset, active HIGH despite the name
//   i_valid_in    in   [p]    ingress packet valid
//   i_source_in   in   [p]    one-hot sender id, passed through unchecked
//   i_target_in   in   [p]    destination bitmap
//   i_data_in     in   [p]    payload
//   o_ready_out   out  [p]    ingress can accept (FIFO not full, not in reset)
//   o_valid_out   out  [p]    egress packet valid, one cycle per packet
//   o_source_out  out  [p]    forwarded source field
//   o_target_out  out  [p]    forwarded target field, unmodified
//   o_data_out    out  [p]    forwarded payload
// ---------------------------------------------------------------------------
module switch_4port #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           i_valid_in,
    input  logic [3:0][3:0]      i_source_in,
    input  logic [3:0][3:0]      i_target_in,
    input  logic [3:0][DW-1:0]   i_data_in,
    output logic [3:0]           o_ready_out,
    output logic [3:0]           o_valid_out,
    output logic [3:0][3:0]      o_source_out,
    output logic [3:0][3:0]      o_target_out,
    output logic [3:0][DW-1:0]   o_data_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_wrPtr   [4];
    logic [PW-1:0] r_rdPtr   [4];
    logic [CW-1:0] r_count   [4];
    logic [3:0]    r_memSrc  [4][DEPTH];
    logic [3:0]    r_memTgt  [4][DEPTH];
    logic [3:0]    r_memMask [4][DEPTH];
    logic [DW-1:0] r_memData [4][DEPTH];
    logic [1:0]    r_rr      [4];

    logic [3:0]          r_validOut;
    logic [3:0][3:0]     r_sourceOut;
    logic [3:0][3:0]     r_targetOut;
    logic [3:0][DW-1:0]  r_dataOut;

    logic [3:0] w_headValid;
    logic [3:0] w_headMask [4];
    logic [3:0] w_wrMask   [4];
    logic [3:0] w_write;
    logic [3:0] w_pop;
    logic [3:0] w_grantAny;
    logic [1:0] w_grantIdx [4];
    logic [3:0] w_clr      [4];
    logic [3:0] w_newMask  [4];

    // Ingress side: head view, ready, and the working mask of the incoming
    // packet. Ready looks at the count only, so a pop in the same cycle does
    // not open a slot early. A zero working mask means accept-and-discard.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            w_headValid[p] = (r_count[p] != '0);
            w_headMask[p]  = r_memMask[p][r_rdPtr[p]];
            o_ready_out[p] = !rst_n && (r_count[p] != CW'(DEPTH));
            w_wrMask[p]    = i_target_in[p];
`ifdef SWITCH_SELF_FILTER_EN
            w_wrMask[p][p] = 1'b0;
`endif
            w_write[p]     = i_valid_in[p] && o_ready_out[p] && (w_wrMask[p] != 4'b0000);
        end
    end

    // Per-egress round-robin search starting at r_rr[e]. The 2-bit sum wraps
    // naturally, giving the modulo-4 rotation.
    always_comb begin
        for (int e = 0; e < 4; e++) begin
            w_grantAny[e] = 1'b0;
            w_grantIdx[e] = 2'd0;
            for (int k = 0; k < 4; k++) begin
                if (!w_grantAny[e]
                    && w_headValid[r_rr[e] + 2'(k)]
                    && w_headMask[r_rr[e] + 2'(k)][e]) begin
                    w_grantAny[e] = 1'b1;
                    w_grantIdx[e] = r_rr[e] + 2'(k);
                end
            end
        end
    end

    // Collect every egress that granted a head this cycle, strip those bits
    // from the remaining mask, and pop once nothing remains.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_clr[i] = 4'b0000;
            for (int e = 0; e < 4; e++) begin
                if (w_grantAny[e] && (w_grantIdx[e] == 2'(i))) begin
                    w_clr[i][e] = 1'b1;
                end
            end
            w_newMask[i] = w_headMask[i] & ~w_clr[i];
            w_pop[i]     = w_headValid[i] && (w_clr[i] != 4'b0000) && (w_newMask[i] == 4'b0000);
        end
    end

    // FIFO storage, pointer/count bookkeeping and egress output registers.
    // A write and a head-mask update never hit the same entry: wrPtr equals
    // rdPtr only when empty (no head) or full (no write).
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < 4; p++) begin
                r_wrPtr[p]     <= '0;
                r_rdPtr[p]     <= '0;
                r_count[p]     <= '0;
                r_rr[p]        <= 2'd0;
                r_validOut[p]  <= 1'b0;
                r_sourceOut[p] <= 4'b0000;
                r_targetOut[p] <= 4'b0000;
                r_dataOut[p]   <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    r_memMask[p][d] <= 4'b0000;
                end
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (w_write[p]) begin
                    r_memSrc[p][r_wrPtr[p]]  <= i_source_in[p];
                    r_memTgt[p][r_wrPtr[p]]  <= i_target_in[p];
                    r_memData[p][r_wrPtr[p]] <= i_data_in[p];
                    r_memMask[p][r_wrPtr[p]] <= w_wrMask[p];
                    r_wrPtr[p]               <= r_wrPtr[p] + 1'b1;
                end
                if (w_headValid[p] && (w_clr[p] != 4'b0000)) begin
                    r_memMask[p][r_rdPtr[p]] <= w_newMask[p];
                end
                if (w_pop[p]) begin
                    r_rdPtr[p] <= r_rdPtr[p] + 1'b1;
                end
                r_count[p] <= r_count[p] + CW'(w_write[p]) - CW'(w_pop[p]);
            end
            for (int e = 0; e < 4; e++) begin
                r_validOut[e] <= w_grantAny[e];
                if (w_grantAny[e]) begin
                    r_sourceOut[e] <= r_memSrc[w_grantIdx[e]][r_rdPtr[w_grantIdx[e]]];
                    r_targetOut[e] <= r_memTgt[w_grantIdx[e]][r_rdPtr[w_grantIdx[e]]];
                    r_dataOut[e]   <= r_memData[w_grantIdx[e]][r_rdPtr[w_grantIdx[e]]];
                    r_rr[e]        <= w_grantIdx[e] + 2'd1;
                end
            end
        end
    end

    assign o_valid_out  = r_validOut;
    assign o_source_out = r_sourceOut;
    assign o_target_out = r_targetOut;
    assign o_data_out   = r_dataOut;

endmodule

// File: tb/tb_switch_4port.sv
// ---------------------------------------------------------------------------
// tb_switch_4port
//
// Purpose:
//   Directed testbench for switch_4port: reset state, unicast, multicast,
//   round-robin contention, backpressure, zero/self target and mid-flight
//   reset. Expected values are hand-derived; results that depend on the
//   SWITCH_SELF_FILTER_EN macro are selected with the same macro.
// ---------------------------------------------------------------------------
module tb_switch_4port;

    localparam int DEPTH = 4;
    localparam int DW    = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [3:0]          validIn;
    logic [3:0][3:0]     sourceIn;
    logic [3:0][3:0]     targetIn;
    logic [3:0][DW-1:0]  dataIn;
    logic [3:0]          readyOut;
    logic [3:0]          validOut;
    logic [3:0][3:0]     sourceOut;
    logic [3:0][3:0]     targetOut;
    logic [3:0][DW-1:0]  dataOut;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [3:0] expMulticast;
    logic [3:0] expSelf;

    switch_4port #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid_in   (validIn),
        .i_source_in  (sourceIn),
        .i_target_in  (targetIn),
        .i_data_in    (dataIn),
        .o_ready_out  (readyOut),
        .o_valid_out  (validOut),
        .o_source_out (sourceOut),
        .o_target_out (targetOut),
        .o_data_out   (dataOut)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Advance one rising edge and settle; all checks happen here.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int p, input logic [3:0] src,
                                 input logic [3:0] tgt, input logic [DW-1:0] d);
        validIn[p]  = 1'b1;
        sourceIn[p] = src;
        targetIn[p] = tgt;
        dataIn[p]   = d;
    endtask

    task automatic idleAll;
        validIn = 4'b0000;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic doReset;
        idleAll();
        rst_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
    endtask

    // Linear directed sequence.
    initial begin
`ifdef SWITCH_SELF_FILTER_EN
        expMulticast = 4'b1101;
        expSelf      = 4'b0000;
`else
        expMulticast = 4'b1111;
        expSelf      = 4'b0100;
`endif
        rst_n    = 1'b1;
        validIn  = '0;
        sourceIn = '0;
        targetIn = '0;
        dataIn   = '0;

        // Reset state.
        tick();
        tick();
        checkOutput("reset_ready",  32'(readyOut), 32'h0);
        checkOutput("reset_valid",  32'(validOut), 32'h0);
        checkOutput("reset_data",   32'(dataOut), 32'h0);
        checkOutput("reset_source", 32'(sourceOut), 32'h0);
        checkOutput("reset_target", 32'(targetOut), 32'h0);
        rst_n = 1'b0;
        tick();
        checkOutput("release_ready", 32'(readyOut), 32'hF);

        // Unicast port0 -> port2.
        applyStimulus(0, 4'b0001, 4'b0100, 8'hA5);
        tick();
        idleAll();
        checkOutput("uni_n1_valid", 32'(validOut), 32'h0);
        tick();
        checkOutput("uni_valid",  32'(validOut), 32'b0100);
        checkOutput("uni_source", 32'(sourceOut[2]), 32'b0001);
        checkOutput("uni_target", 32'(targetOut[2]), 32'b0100);
        checkOutput("uni_data",   32'(dataOut[2]), 32'hA5);
        tick();
        checkOutput("uni_after_valid", 32'(validOut), 32'h0);
        checkOutput("uni_hold_data",   32'(dataOut[2]), 32'hA5);

        // Multicast from port1 to all ports.
        applyStimulus(1, 4'b0010, 4'b1111, 8'h3C);
        tick();
        idleAll();
        tick();
        checkOutput("mc_valid",   32'(validOut), 32'(expMulticast));
        checkOutput("mc_data0",   32'(dataOut[0]), 32'h3C);
        checkOutput("mc_data2",   32'(dataOut[2]), 32'h3C);
        checkOutput("mc_data3",   32'(dataOut[3]), 32'h3C);
        checkOutput("mc_target3", 32'(targetOut[3]), 32'b1111);
        tick();
        checkOutput("mc_after_valid", 32'(validOut), 32'h0);

        // Contention: all ports to port3, two bursts, order 0,1,2,3 each time.
        doReset();
        for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < 4; p++) begin
                applyStimulus(p, 4'(1 << p), 4'b1000, 8'(8'h10 * (b + 1) + p));
            end
            tick();
            idleAll();
            checkOutput("cont_accept_valid", 32'(validOut), 32'h0);
            for (int k = 0; k < 4; k++) begin
                tick();
                checkOutput("cont_valid", 32'(validOut), 32'b1000);
                checkOutput("cont_data",  32'(dataOut[3]), 32'(8'h10 * (b + 1) + k));
            end
            tick();
            checkOutput("cont_drain_valid", 32'(validOut), 32'h0);
        end

        // Backpressure: all ports hammer egress3; port0 fills after 5 accepts.
        doReset();
        for (int p = 0; p < 4; p++) begin
            applyStimulus(p, 4'(1 << p), 4'b1000, 8'(8'h30 + p));
        end
        tick();
        checkOutput("bp_e1_ready0", 32'(readyOut[0]), 32'h1);
        tick();
        checkOutput("bp_e2_data", 32'(dataOut[3]), 32'h30);
        tick();
        checkOutput("bp_e3_data", 32'(dataOut[3]), 32'h31);
        tick();
        checkOutput("bp_e4_ready0", 32'(readyOut[0]), 32'h1);
        checkOutput("bp_e4_ready3", 32'(readyOut[3]), 32'h0);
        checkOutput("bp_e4_data",   32'(dataOut[3]), 32'h32);
        tick();
        checkOutput("bp_e5_ready0", 32'(readyOut[0]), 32'h0);
        checkOutput("bp_e5_data",   32'(dataOut[3]), 32'h33);
        tick();
        checkOutput("bp_e6_ready0", 32'(readyOut[0]), 32'h1);
        checkOutput("bp_e6_data",   32'(dataOut[3]), 32'h30);
        checkOutput("bp_e6_valid",  32'(validOut), 32'b1000);

        // Zero target then self target on port2.
        doReset();
        applyStimulus(2, 4'b0100, 4'b0000, 8'h55);
        tick();
        checkOutput("zero_ready2", 32'(readyOut[2]), 32'h1);
        applyStimulus(2, 4'b0100, 4'b0100, 8'h66);
        tick();
        idleAll();
        checkOutput("self_ready2", 32'(readyOut[2]), 32'h1);
        checkOutput("zero_valid",  32'(validOut), 32'h0);
        tick();
        checkOutput("self_valid",  32'(validOut), 32'(expSelf));
        tick();
        checkOutput("self_after_valid", 32'(validOut), 32'h0);

        // Reset mid-flight.
        doReset();
        applyStimulus(0, 4'b0001, 4'b0010, 8'h71);
        tick();
        dataIn[0] = 8'h72;
        tick();
        dataIn[0] = 8'h73;
        tick();
        idleAll();
        checkOutput("mf_pre_data", 32'(dataOut[1]), 32'h72);
        rst_n = 1'b1;
        tick();
        checkOutput("mf_rst_valid", 32'(validOut), 32'h0);
        checkOutput("mf_rst_ready", 32'(readyOut), 32'h0);
        checkOutput("mf_rst_data",  32'(dataOut), 32'h0);
        rst_n = 1'b0;
        tick();
        checkOutput("mf_rel_valid", 32'(validOut), 32'h0);
        checkOutput("mf_rel_ready", 32'(readyOut), 32'hF);
        tick();
        checkOutput("mf_rel2_valid", 32'(validOut), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
